// File: rtl/difftest_step_batcher_if.sv
// Commit-count stream into the step batcher plus its step/pending/halted results.
// master drives counts and control; slave is the batcher.
interface difftest_step_batcher_if #(
  parameter int STEP_W = 8,
  parameter int CNT_W  = 4
);
  logic              in_valid;
  logic [CNT_W-1:0]  in_count;
  logic              flush;
  logic [7:0]        simv_result;
  logic [STEP_W-1:0] step;
  logic [STEP_W-1:0] pending;
  logic              halted;

  modport master (
    output in_valid, in_count, flush, simv_result,
    input  step, pending, halted
  );

  modport slave (
    input  in_valid, in_count, flush, simv_result,
    output step, pending, halted
  );
endinterface

// File: rtl/difftest_step_batcher.sv
// Batches per-cycle commit counts into one-cycle step pulses (1-cycle latency, no backpressure: every input is absorbed).
// Idle-timeout emission exists only when CONFIG_DIFFTEST_STEP_TIMEOUT_EN is defined.
module difftest_step_batcher #(
  parameter int STEP_W  = 8,
  parameter int CNT_W   = 4,
  parameter int BATCH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  difftest_step_batcher_if.slave io
);
  typedef enum logic [1:0] {IDLE, ACCUM, HALTED} state_t;

  state_t            state;
  logic [STEP_W-1:0] acc;
  logic [STEP_W:0]   inc;
  logic [STEP_W:0]   sum;
  logic              ovf;
  logic              emit;
  logic              timeout_hit;

  generate
    if (CNT_W > STEP_W || BATCH < 1 || BATCH > 2**STEP_W - 1 || TIMEOUT < 2) begin : g_bad_param
      $error("difftest_step_batcher: illegal parameter combination");
    end
  endgenerate

  assign inc  = io.in_valid ? {{(STEP_W + 1 - CNT_W){1'b0}}, io.in_count} : '0;
  assign sum  = {1'b0, acc} + inc;
  assign ovf  = sum[STEP_W];
  assign emit = io.flush || (sum >= (STEP_W + 1)'(BATCH)) || timeout_hit;
  assign io.pending = acc;

`ifdef CONFIG_DIFFTEST_STEP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  logic [TW-1:0] timer;

  assign timeout_hit = (state == ACCUM) && (timer == TW'(TIMEOUT - 1));

  // Timer only runs while a partial batch sits in ACCUM without emitting.
  always_ff @(posedge clock) begin
    if (!reset || state == HALTED || io.simv_result != 8'd0) begin
      timer <= '0;
    end else if (ovf || emit || state != ACCUM) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Halt outranks every emission, so the cycle's pending count is dropped.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      acc       <= '0;
      io.step   <= '0;
      io.halted <= 1'b0;
    end else if (state == HALTED || io.simv_result != 8'd0) begin
      state     <= HALTED;
      acc       <= '0;
      io.step   <= '0;
      io.halted <= 1'b1;
    end else if (ovf) begin
      // acc + inc does not fit: ship acc alone, inc (non-zero here) opens the next batch.
      state   <= ACCUM;
      io.step <= acc;
      acc     <= inc[STEP_W-1:0];
    end else if (emit) begin
      state   <= IDLE;
      io.step <= sum[STEP_W-1:0];
      acc     <= '0;
    end else begin
      state   <= (sum != '0) ? ACCUM : IDLE;
      io.step <= '0;
      acc     <= sum[STEP_W-1:0];
    end
  end
endmodule

// File: tb/tb_difftest_step_batcher.sv
// Directed bench for difftest_step_batcher: a BATCH=16 instance and a BATCH=255 instance for overflow.
// Expected step/pending/halted are queued as stimulus is driven and compared one cycle later.
module tb_difftest_step_batcher;
  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  difftest_step_batcher_if #(.STEP_W(8), .CNT_W(4)) io ();
  difftest_step_batcher_if #(.STEP_W(8), .CNT_W(4)) io2 ();

  difftest_step_batcher #(.STEP_W(8), .CNT_W(4), .BATCH(16), .TIMEOUT(64)) dut (
    .clock (clock),
    .reset (reset),
    .io    (io)
  );

  difftest_step_batcher #(.STEP_W(8), .CNT_W(4), .BATCH(255), .TIMEOUT(64)) dut_ov (
    .clock (clock),
    .reset (reset),
    .io    (io2)
  );

  typedef struct {
    string      tag;
    int         which;
    logic [7:0] st;
    logic [7:0] pd;
    logic       h;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input string what, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s %s observed %0d expected %0d", tag, what, obs, expv);
    end
  endtask

  // Drive one cycle of stimulus on instance 'which', queue the expected result, compare after the edge.
  task automatic cyc(input int which, input string tag, input logic v, input logic [3:0] c,
                     input logic f, input logic [7:0] r,
                     input logic [7:0] es, input logic [7:0] ep, input logic eh);
    exp_t e;
    exp_t got;
    logic [7:0] ost, opd;
    logic oh;
    if (which == 0) begin
      io.in_valid = v; io.in_count = c; io.flush = f; io.simv_result = r;
    end else begin
      io2.in_valid = v; io2.in_count = c; io2.flush = f; io2.simv_result = r;
    end
    e.tag = tag; e.which = which; e.st = es; e.pd = ep; e.h = eh;
    sb.push_back(e);
    @(posedge clock);
    #1;
    got = sb.pop_front();
    if (got.which == 0) begin
      ost = io.step; opd = io.pending; oh = io.halted;
    end else begin
      ost = io2.step; opd = io2.pending; oh = io2.halted;
    end
    chk(got.tag, "step", ost, got.st);
    chk(got.tag, "pending", opd, got.pd);
    chk(got.tag, "halted", {7'd0, oh}, {7'd0, got.h});
  endtask

  initial begin
    io.in_valid = 1'b0;  io.in_count = '0;  io.flush = 1'b0;  io.simv_result = '0;
    io2.in_valid = 1'b0; io2.in_count = '0; io2.flush = 1'b0; io2.simv_result = '0;

    reset = 1'b0;
    cyc(0, "reset_main", 0, 0, 0, 0, 8'd0, 8'd0, 1'b0);
    cyc(1, "reset_ov",   0, 0, 0, 0, 8'd0, 8'd0, 1'b0);
    reset = 1'b1;

    // Overflow instance (BATCH=255): exact 255 emits via threshold, 265 overflows.
    for (int i = 1; i <= 16; i++) cyc(1, "ov_fill_a", 1, 4'd15, 0, 0, 8'd0, 8'(15 * i), 1'b0);
    cyc(1, "ov_exact_max", 1, 4'd15, 0, 0, 8'd255, 8'd0, 1'b0);
    for (int i = 1; i <= 16; i++) cyc(1, "ov_fill_b", 1, 4'd15, 0, 0, 8'd0, 8'(15 * i), 1'b0);
    cyc(1, "ov_to_250", 1, 4'd10, 0, 0, 8'd0, 8'd250, 1'b0);
    cyc(1, "ov_overflow", 1, 4'd15, 0, 0, 8'd250, 8'd15, 1'b0);
    cyc(1, "ov_flush_rest", 0, 4'd0, 1, 0, 8'd15, 8'd0, 1'b0);
    cyc(1, "ov_idle", 0, 4'd0, 0, 0, 8'd0, 8'd0, 1'b0);

    // Threshold: four counts of 4 emit 16 once.
    cyc(0, "thr_1", 1, 4'd4, 0, 0, 8'd0, 8'd4, 1'b0);
    cyc(0, "thr_2", 1, 4'd4, 0, 0, 8'd0, 8'd8, 1'b0);
    cyc(0, "thr_3", 1, 4'd4, 0, 0, 8'd0, 8'd12, 1'b0);
    cyc(0, "thr_4", 1, 4'd4, 0, 0, 8'd16, 8'd0, 1'b0);
    cyc(0, "thr_after", 0, 4'd0, 0, 0, 8'd0, 8'd0, 1'b0);
    cyc(0, "invalid_ignored", 0, 4'd9, 0, 0, 8'd0, 8'd0, 1'b0);

    // Flush with and without pending work.
    cyc(0, "fl_load", 1, 4'd7, 0, 0, 8'd0, 8'd7, 1'b0);
    cyc(0, "fl_emit", 1, 4'd2, 1, 0, 8'd9, 8'd0, 1'b0);
    cyc(0, "fl_after", 0, 4'd0, 0, 0, 8'd0, 8'd0, 1'b0);
    cyc(0, "fl_empty", 0, 4'd0, 1, 0, 8'd0, 8'd0, 1'b0);

    // Back-to-back emissions.
    cyc(0, "b2b_load", 1, 4'd10, 0, 0, 8'd0, 8'd10, 1'b0);
    cyc(0, "b2b_thr", 1, 4'd8, 0, 0, 8'd18, 8'd0, 1'b0);
    cyc(0, "b2b_flush", 1, 4'd15, 1, 0, 8'd15, 8'd0, 1'b0);
    cyc(0, "b2b_after", 0, 4'd0, 0, 0, 8'd0, 8'd0, 1'b0);

    // Partial batch left idle.
    cyc(0, "tmo_load", 1, 4'd3, 0, 0, 8'd0, 8'd3, 1'b0);
`ifdef CONFIG_DIFFTEST_STEP_TIMEOUT_EN
    for (int i = 1; i <= 63; i++) cyc(0, "tmo_wait", 0, 4'd0, 0, 0, 8'd0, 8'd3, 1'b0);
    cyc(0, "tmo_fire", 0, 4'd0, 0, 0, 8'd3, 8'd0, 1'b0);
`else
    for (int i = 1; i <= 80; i++) cyc(0, "tmo_hold", 0, 4'd0, 0, 0, 8'd0, 8'd3, 1'b0);
    cyc(0, "tmo_flush", 0, 4'd0, 1, 0, 8'd3, 8'd0, 1'b0);
`endif
    cyc(0, "tmo_after", 0, 4'd0, 0, 0, 8'd0, 8'd0, 1'b0);

    // Reset mid-batch discards the partial batch.
    cyc(0, "rst_load", 1, 4'd9, 0, 0, 8'd0, 8'd9, 1'b0);
    reset = 1'b0;
    cyc(0, "rst_apply", 0, 4'd0, 0, 0, 8'd0, 8'd0, 1'b0);
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) cyc(0, "rst_fresh", 1, 4'd4, 0, 0, 8'd0, 8'(4 * i), 1'b0);
    cyc(0, "rst_fresh_emit", 1, 4'd4, 0, 0, 8'd16, 8'd0, 1'b0);

    // Halt wins over the same-cycle input and sticks until reset.
    cyc(0, "halt_load", 1, 4'd5, 0, 0, 8'd0, 8'd5, 1'b0);
    cyc(0, "halt_hit", 1, 4'd15, 0, 8'd1, 8'd0, 8'd0, 1'b1);
    cyc(0, "halt_in", 1, 4'd15, 0, 8'd0, 8'd0, 8'd0, 1'b1);
    cyc(0, "halt_in2", 1, 4'd15, 0, 8'd0, 8'd0, 8'd0, 1'b1);
    cyc(0, "halt_flush", 1, 4'd3, 1, 8'd0, 8'd0, 8'd0, 1'b1);
    cyc(0, "halt_idle", 0, 4'd0, 0, 8'd0, 8'd0, 8'd0, 1'b1);
    reset = 1'b0;
    cyc(0, "halt_reset", 0, 4'd0, 0, 8'd0, 8'd0, 8'd0, 1'b0);
    reset = 1'b1;
    cyc(0, "post_halt_load", 1, 4'd4, 0, 8'd0, 8'd0, 8'd4, 1'b0);
    cyc(0, "post_halt_flush", 0, 4'd0, 1, 8'd0, 8'd4, 8'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/difftest_step_batcher.md
# difftest_step_batcher

Upstream feeder of the deferred-result control stage. Sums per-cycle commit counts from the DUT difftest probes into batched step values, so the DPI step call fires rarely and with large counts. Emits one registered `step` pulse when a batch threshold, an idle timeout or an explicit flush is reached. Freezes all stepping once the software side reports a non-zero deferred result.

## Interface
- `STEP_W`, 8: width of `step`; must equal `CONFIG_DIFFTEST_STEPWIDTH`.
- `CNT_W`, 4: width of the per-cycle commit count; requires `CNT_W <= STEP_W`.
- `BATCH`, 16: emit threshold; requires `1 <= BATCH <= 2^STEP_W-1`.
- `TIMEOUT`, 64: idle-flush limit in cycles; requires `>= 2`. Used only with the timeout feature.

Ports:
- `clock` input 1: clock.
- `reset` input 1: reset, synchronous, active-low.
- `in_valid` input 1: `in_count` is valid this cycle.
- `in_count` input CNT_W: instructions committed this cycle; 0 is legal.
- `flush` input 1: emit everything pending now (e.g. end of simulation).
- `simv_result` input 8: deferred result from the downstream stage; non-zero means halt.
- `step` output STEP_W: registered step count; 0 when idle.
- `pending` output STEP_W: current accumulator value.
- `halted` output 1: sticky halt indication.

## Operation
- State machine: `IDLE` (acc==0), `ACCUM` (acc>0), `HALTED`.
- Increment: `inc = in_valid ? in_count : 0`, zero-extended to STEP_W+1 bits. `sum = acc + inc`, computed at STEP_W+1 bits.
- Emit, in priority order (highest first):
  1. `sum > 2^STEP_W-1` (overflow): `step <= acc`, `acc <= inc`.
  2. `flush`, or `sum >= BATCH`, or timeout hit: `step <= sum`, `acc <= 0`.
  3. Otherwise: `step <= 0`, `acc <= sum`.
- `flush` with `sum==0`: no emission; `step` stays 0.
- Transitions:
  - `IDLE` -> `ACCUM` when the next acc is non-zero.
  - `ACCUM` -> `IDLE` on an emission that leaves acc at 0.
  - Any state -> `HALTED` when `simv_result != 0` is sampled.
- `HALTED` behaviour:
  - acc cleared; `step` held at 0; inputs ignored.
  - Exit only by reset.
  - The halt takes priority over any emission in the same cycle, so that cycle's pending count is discarded.
- Timer:
  - Counts cycles spent in `ACCUM` without an emission; cleared on every emission and when entering `IDLE`.
  - Timeout hit when `timer == TIMEOUT-1` in `ACCUM`.

## Timing
- All outputs are registered.
- Reset values: `step=0`, `pending=0`, `halted=0`, state `IDLE`, timer 0.
- Latency: the input sampled at cycle t appears in `step` at cycle t+1, or is carried in acc.
- `step` is non-zero for exactly one cycle per emission. Back-to-back emissions on consecutive cycles are legal.
- `halted` rises one cycle after a non-zero `simv_result` is sampled.
- `pending` reflects acc after the same edge that updates `step`.
- Reset asserted mid-batch discards acc with no emission. The first cycle after reset release behaves as `IDLE`.
- Conservation: with no halt, the sum of all emitted `step` values plus `pending` equals the sum of all accepted `inc`.

## Configuration
- `CONFIG_DIFFTEST_STEP_TIMEOUT_EN` defined: the timer and timeout emission are present.
- Not defined:
  - No timer logic.
  - Emission happens only on threshold, overflow or `flush`.
  - `TIMEOUT` is ignored.
  - A partial batch waits indefinitely.

## Test plan
Parameters for all scenarios: STEP_W=8, CNT_W=4, BATCH=16, TIMEOUT=64.
- Threshold: `in_count=4` valid for 4 consecutive cycles -> `step=16` for one cycle on the cycle after the 4th input; `pending=0`.
- Timeout (macro on): a single `in_count=3`, then idle -> `step=3` exactly 64 cycles after entering `ACCUM`. With the macro off -> `step` stays 0 and `pending=3`.
- Flush: `pending=7`, then `flush` with `in_count=2` -> `step=9` next cycle. Flush with `pending=0` and no input -> `step` stays 0.
- Overflow: BATCH=255 build, accumulate 250, then `in_count=15` -> `step=250`, `pending=15`.
- Halt: `pending=5`, then `simv_result=1` while also `in_count=15` -> `step` stays 0, `halted=1`, `pending=0`. Later inputs and flushes produce no step until reset.
- Reset mid-batch: `pending=9`, then reset low for one cycle -> `step=0`, `pending=0`, `halted=0`. A fresh batch of 16 then emits `step=16`.
